pipe_stage_skid: RTL and testbench

- Parametrised, generic inter-stage pipeline register that replaces the fixed per-stage enable/flush registers (IF/ID, ID/EX, ...).
- Uses a valid/ready handshake with an optional 2-entry skid buffer, so upstream back-pressure is registered and never a long combinational path.
- Supports flush (bubble insertion) and keeps saturating stall/bubble counters for the benchmarking framework.
- Sits between any two pipeline stages. The payload is an opaque bundle (PC, instruction, prediction sideband).

---
 rtl/pipe_stage_skid_if.sv | 26 ++
 rtl/pipe_stage_skid.sv | 104 ++++++++++
 tb/tb_pipe_stage_skid.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream valid/ready/data, downstream
// valid/ready/data, flush and the performance counters.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 97,
  parameter int unsigned CNT_W  = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, stall_cnt, bubble_cnt
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, flush and saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int unsigned DATA_W  = 97,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipe_stage_skid_if.slave bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;

  logic out_valid;
  logic in_ready;
  logic in_xfer;

  assign out_valid = (state_q != ST_EMPTY);
  // Without the skid entry, readiness must follow out_ready in the same cycle.
  assign in_ready  = (SKID_EN != 0) ? in_ready_q : (!out_valid || bus.out_ready);
  assign in_xfer   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = bus.in_data;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_xfer && bus.out_ready) begin
            main_d = bus.in_data;
          end else if (in_xfer) begin
            skid_d  = bus.in_data;
            state_d = ST_FULL;
          end else if (bus.out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !bus.out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (!out_valid && (bubble_q != '1)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
      bubble_q   <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
      bubble_q   <= bubble_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = main_q;
  assign bus.stall_cnt  = stall_q;
  assign bus.bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid, no-skid and 4-bit-counter variants.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 16;

  logic clk;
  logic rst;

  pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(32)) bus_skid ();
  pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(32)) bus_nosk ();
  pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(4))  bus_sat  ();

  pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1), .CNT_W(32)) u_skid (
    .clk(clk), .rst(rst), .bus(bus_skid.slave)
  );
  pipe_stage_skid #(.DATA_W(DW), .SKID_EN(0), .CNT_W(32)) u_nosk (
    .clk(clk), .rst(rst), .bus(bus_nosk.slave)
  );
  pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .bus(bus_sat.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          ev;
    logic [DW-1:0] ed;
    logic          eir;
    int unsigned   eb;
    int unsigned   es;
  } vec_t;

  vec_t vecs [19];
  int total;
  int bad;

  function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic ordy, logic ev,
                              logic [DW-1:0] ed, logic eir, int unsigned eb,
                              int unsigned es);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.ev = ev;
    v.ed = ed; v.eir = eir; v.eb = eb; v.es = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // stream 1..8, then back-pressure with A=0x10, B=0x20
    vecs[0]  = mk(0, 16'h0,  1, 0, 16'h0,  1, 0, 0);
    vecs[1]  = mk(0, 16'h0,  1, 0, 16'h0,  1, 1, 0);
    vecs[2]  = mk(1, 16'h1,  1, 0, 16'h0,  1, 2, 0);
    vecs[3]  = mk(1, 16'h2,  1, 1, 16'h1,  1, 3, 0);
    vecs[4]  = mk(1, 16'h3,  1, 1, 16'h2,  1, 3, 0);
    vecs[5]  = mk(1, 16'h4,  1, 1, 16'h3,  1, 3, 0);
    vecs[6]  = mk(1, 16'h5,  1, 1, 16'h4,  1, 3, 0);
    vecs[7]  = mk(1, 16'h6,  1, 1, 16'h5,  1, 3, 0);
    vecs[8]  = mk(1, 16'h7,  1, 1, 16'h6,  1, 3, 0);
    vecs[9]  = mk(1, 16'h8,  1, 1, 16'h7,  1, 3, 0);
    vecs[10] = mk(0, 16'h0,  1, 1, 16'h8,  1, 3, 0);
    vecs[11] = mk(0, 16'h0,  1, 0, 16'h8,  1, 3, 0);
    vecs[12] = mk(1, 16'h10, 1, 0, 16'h8,  1, 4, 0);
    vecs[13] = mk(1, 16'h20, 0, 1, 16'h10, 1, 5, 0);
    vecs[14] = mk(0, 16'h0,  0, 1, 16'h10, 0, 5, 1);
    vecs[15] = mk(0, 16'h0,  0, 1, 16'h10, 0, 5, 2);
    vecs[16] = mk(0, 16'h0,  1, 1, 16'h10, 0, 5, 3);
    vecs[17] = mk(0, 16'h0,  1, 1, 16'h20, 1, 5, 3);
    vecs[18] = mk(0, 16'h0,  1, 0, 16'h20, 1, 5, 3);

    rst = 1'b1;
    bus_skid.flush = 0; bus_skid.in_valid = 0; bus_skid.in_data = '0; bus_skid.out_ready = 0;
    bus_nosk.flush = 0; bus_nosk.in_valid = 0; bus_nosk.in_data = '0; bus_nosk.out_ready = 0;
    bus_sat.flush  = 0; bus_sat.in_valid  = 0; bus_sat.in_data  = '0; bus_sat.out_ready  = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(bus_skid.out_valid), 64'd0);
    check("rst_out_data",  64'(bus_skid.out_data),  64'd0);
    check("rst_in_ready",  64'(bus_skid.in_ready),  64'd1);
    check("rst_stall",     64'(bus_skid.stall_cnt), 64'd0);
    check("rst_bubble",    64'(bus_skid.bubble_cnt), 64'd0);
    check("rst_nosk_in_ready", 64'(bus_nosk.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      bus_skid.in_valid  = vecs[i].iv;
      bus_skid.in_data   = vecs[i].d;
      bus_skid.out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_out_valid", i), 64'(bus_skid.out_valid), 64'(vecs[i].ev));
      check($sformatf("vec%0d_out_data", i),  64'(bus_skid.out_data),  64'(vecs[i].ed));
      check($sformatf("vec%0d_in_ready", i),  64'(bus_skid.in_ready),  64'(vecs[i].eir));
      check($sformatf("vec%0d_bubble", i),    64'(bus_skid.bubble_cnt), 64'(vecs[i].eb));
      check($sformatf("vec%0d_stall", i),     64'(bus_skid.stall_cnt), 64'(vecs[i].es));
      @(negedge clk);
    end

    // flush while FULL with 0x10/0x20 and 0x30 offered
    bus_skid.in_valid = 1; bus_skid.in_data = 16'h10; bus_skid.out_ready = 1;
    @(negedge clk);
    bus_skid.in_data = 16'h20; bus_skid.out_ready = 0;
    #1;
    check("fl_busy_data", 64'(bus_skid.out_data), 64'h10);
    @(negedge clk);
    bus_skid.in_data = 16'h30; bus_skid.flush = 1;
    #1;
    check("fl_full_in_ready", 64'(bus_skid.in_ready), 64'd0);
    @(negedge clk);
    bus_skid.flush = 0; bus_skid.in_valid = 0; bus_skid.out_ready = 1;
    #1;
    check("fl_after_out_valid", 64'(bus_skid.out_valid), 64'd0);
    check("fl_after_in_ready",  64'(bus_skid.in_ready),  64'd1);
    check("fl_data_held",       64'(bus_skid.out_data),  64'h10);
    check("fl_stall",           64'(bus_skid.stall_cnt), 64'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("fl_drain%0d_out_valid", i), 64'(bus_skid.out_valid), 64'd0);
    end
    // flush drops an offer even when the stage is ready
    bus_skid.in_valid = 1; bus_skid.in_data = 16'h40; bus_skid.flush = 1;
    #1;
    check("fl_empty_in_ready", 64'(bus_skid.in_ready), 64'd1);
    @(negedge clk);
    bus_skid.in_valid = 0; bus_skid.flush = 0;
    #1;
    check("fl_drop_out_valid", 64'(bus_skid.out_valid), 64'd0);
    check("fl_drop_out_data",  64'(bus_skid.out_data),  64'h10);

    // single-register variant
    bus_nosk.in_valid = 1; bus_nosk.in_data = 16'h55; bus_nosk.out_ready = 0;
    #1;
    check("ns_empty_in_ready", 64'(bus_nosk.in_ready), 64'd1);
    @(negedge clk);
    bus_nosk.in_data = 16'h66;
    #1;
    check("ns_out_data0",   64'(bus_nosk.out_data), 64'h55);
    check("ns_in_ready_bp", 64'(bus_nosk.in_ready), 64'd0);
    bus_nosk.out_ready = 1;
    #1;
    check("ns_in_ready_comb", 64'(bus_nosk.in_ready), 64'd1);
    @(negedge clk);
    bus_nosk.in_data = 16'h77;
    #1;
    check("ns_out_data1", 64'(bus_nosk.out_data), 64'h66);
    check("ns_in_ready1", 64'(bus_nosk.in_ready), 64'd1);
    @(negedge clk);
    bus_nosk.in_valid = 0; bus_nosk.out_ready = 0;
    #1;
    check("ns_out_data2",  64'(bus_nosk.out_data),  64'h77);
    check("ns_out_valid2", 64'(bus_nosk.out_valid), 64'd1);
    check("ns_in_ready2",  64'(bus_nosk.in_ready),  64'd0);
    @(negedge clk);
    #1;
    check("ns_hold_data", 64'(bus_nosk.out_data), 64'h77);

    // 4-bit counters saturate
    check("sat_bubble", 64'(bus_sat.bubble_cnt), 64'd15);
    bus_sat.in_valid = 1; bus_sat.in_data = 16'hAA; bus_sat.out_ready = 0;
    @(negedge clk);
    bus_sat.in_valid = 0;
    repeat (20) @(negedge clk);
    #1;
    check("sat_stall20", 64'(bus_sat.stall_cnt), 64'd15);
    @(negedge clk);
    #1;
    check("sat_stall21", 64'(bus_sat.stall_cnt), 64'd15);
    check("sat_out_data", 64'(bus_sat.out_data), 64'hAA);

    // push into FULL, then assert reset between edges
    bus_sat.in_valid = 1; bus_sat.in_data = 16'hBB;
    @(negedge clk);
    bus_sat.in_valid = 0;
    #1;
    check("ar_full_in_ready", 64'(bus_sat.in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 64'(bus_sat.out_valid),  64'd0);
    check("ar_out_data",  64'(bus_sat.out_data),   64'd0);
    check("ar_stall",     64'(bus_sat.stall_cnt),  64'd0);
    check("ar_bubble",    64'(bus_sat.bubble_cnt), 64'd0);
    check("ar_in_ready",  64'(bus_sat.in_ready),   64'd1);
    check("ar_skid_stall", 64'(bus_skid.stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_sat.out_ready = 1;
    #1;
    check("ar_rel_out_valid", 64'(bus_sat.out_valid), 64'd0);
    @(negedge clk);
    #1;
    check("ar_rel2_out_valid", 64'(bus_sat.out_valid),  64'd0);
    check("ar_rel2_bubble",    64'(bus_sat.bubble_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
